imem_loader: RTL and testbench

// - Boot-time stage directly upstream of the processor core: fills instruction memory before execution starts.
// - Accepts a byte stream (valid/ready) and assembles big-endian 32-bit words.
// - Writes each word to instruction memory through a single write port.
// - Holds the core stalled (cpu_run=0) until the image is complete.

---
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : boot loader, byte stream -> big-endian words -> instr memory
// Revision    : 1.0
// ============================================================================
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              len_err
);

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // One bit wider than the 16-bit length so the depth compare never truncates
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;

  logic        xfer;
  logic [15:0] idx_next;
  logic [15:0] n_new;

  assign xfer     = rx_valid & rx_ready;
  assign idx_next = word_idx + 16'd1;
  assign n_new    = {len_hi, rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN_HI;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
      load_done  <= 1'b0;
      len_err    <= 1'b0;
      len_hi     <= 8'd0;
      word_cnt   <= 16'd0;
      word_idx   <= 16'd0;
      byte_cnt   <= 2'd0;
      shift      <= 24'd0;
    end else begin
      case (state)
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            word_cnt <= n_new;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            if ({1'b0, n_new} > DEPTH) begin
              len_err <= 1'b1;
            end
            if (n_new == 16'd0) begin
              state     <= S_DONE;
              rx_ready  <= 1'b0;
              cpu_run   <= 1'b1;
              load_done <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            shift    <= {shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            // Fourth byte: present the word so the strobe is high during WRITE
            if (byte_cnt == 2'd3) begin
              state      <= S_WRITE;
              rx_ready   <= 1'b0;
              imem_we    <= ({1'b0, word_idx} < DEPTH);
              imem_addr  <= word_idx[ADDR_W-1:0];
              imem_wdata <= {shift, rx_data};
            end
          end
        end

        S_WRITE: begin
          imem_we  <= 1'b0;
          word_idx <= idx_next;
          if (idx_next == word_cnt) begin
            state     <= S_DONE;
            cpu_run   <= 1'b1;
            load_done <= 1'b1;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end

        S_DONE: begin
          if (reload) begin
            state     <= S_LEN_HI;
            rx_ready  <= 1'b1;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            len_err   <= 1'b0;
            word_idx  <= 16'd0;
            byte_cnt  <= 2'd0;
          end
        end

        default: begin
          state    <= S_LEN_HI;
          rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader : randomized image loads checked by a write scoreboard
module tb_imem_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_run;
  logic              load_done;
  logic              len_err;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .len_err    (len_err)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img_words[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int xfer_neg = 0;
  int done_cyc = -1;
  int low_cnt  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: bookkeeping of transfers/done, and scoreboard pop on each write
  always @(negedge clk) begin : mon
    wr_t e;
    if (rx_valid && rx_ready) xfer_neg = cyc;
    if (!rx_ready && !load_done) low_cnt++;
    if (load_done && done_cyc < 0) done_cyc = cyc;
    if (imem_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual addr=%0h data=%h required none", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          bad++;
          $display("FAIL write actual addr=%0h data=%h required addr=%0h data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
      total++;
      if (cyc != xfer_neg + 1) begin
        bad++;
        $display("FAIL write_latency actual=%0d required=%0d", cyc - xfer_neg, 1);
      end
      total++;
      if (rx_ready !== 1'b0) begin
        bad++;
        $display("FAIL ready_in_write actual=%b required=0", rx_ready);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset();
    chk("rst_rx_ready",   32'(rx_ready),   32'd1);
    chk("rst_imem_we",    32'(imem_we),    32'd0);
    chk("rst_imem_addr",  32'(imem_addr),  32'd0);
    chk("rst_imem_wdata", imem_wdata,      32'd0);
    chk("rst_cpu_run",    32'(cpu_run),    32'd0);
    chk("rst_load_done",  32'(load_done),  32'd0);
    chk("rst_len_err",    32'(len_err),    32'd0);
  endtask

  // Offer one byte (after random idle gaps) and hold it until accepted
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    bit acc;
    int guard;
    while (int'($urandom_range(99)) < gap_pct) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    guard    = 0;
    acc      = 1'b0;
    while (!acc && guard < 50) begin
      acc = rx_ready;
      @(posedge clk); #1;
      guard++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL byte_accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  // Reference model: words with index < DEPTH land at their index; others vanish
  task automatic run_image(input int n, input int gap, input bit noisy);
    logic [7:0]  bq[$];
    logic [15:0] nn;
    logic [31:0] w;
    int guard;
    nn = n[15:0];
    low_cnt  = 0;
    done_cyc = -1;
    bq.push_back(nn[15:8]);
    bq.push_back(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      w = img_words[i];
      bq.push_back(w[31:24]);
      bq.push_back(w[23:16]);
      bq.push_back(w[15:8]);
      bq.push_back(w[7:0]);
      if (i < DEPTH) exp_q.push_back(wr_t'{addr: i[ADDR_W-1:0], data: w});
    end
    reload = noisy;
    for (int k = 0; k < bq.size(); k++) begin
      if (k == bq.size() - 1) reload = 1'b0;
      send_byte(bq[k], gap);
    end
    guard = 0;
    while (done_cyc < 0 && guard < 20) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("done_seen",    32'(done_cyc >= 0), 32'd1);
    chk("done_latency", 32'(done_cyc - xfer_neg), (n == 0) ? 32'd1 : 32'd2);
    chk("cpu_run",      32'(cpu_run), 32'd1);
    chk("len_err",      32'(len_err), 32'(n > DEPTH));
    chk("ready_low_cycles", 32'(low_cnt), 32'(n));
    chk("writes_left",  32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    @(negedge clk);
    chk("reload_cpu_run",   32'(cpu_run),   32'd0);
    chk("reload_load_done", 32'(load_done), 32'd0);
    chk("reload_len_err",   32'(len_err),   32'd0);
    chk("reload_rx_ready",  32'(rx_ready),  32'd1);
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    reload   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset();

    img_words.delete();
    img_words.push_back(32'hDEADBEEF);
    run_image(1, 0, 1'b0);

    do_reload();
    img_words.delete();
    img_words.push_back(32'h11111111);
    img_words.push_back(32'h22222222);
    img_words.push_back(32'h33333333);
    run_image(3, 0, 1'b1);

    do_reload();
    img_words.delete();
    run_image(0, 0, 1'b0);

    do_reload();
    img_words.delete();
    for (int i = 0; i < 5; i++) img_words.push_back($urandom);
    run_image(5, 0, 1'b0);

    // Abort a load mid-word with reset, then load a fresh image
    do_reload();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset();
    img_words.delete();
    img_words.push_back(32'hCAFEF00D);
    run_image(1, 0, 1'b0);

    do_reload();
    img_words.delete();
    img_words.push_back(32'h01234567);
    run_image(1, 40, 1'b0);

    for (int r = 0; r < 10; r++) begin
      do_reload();
      n = int'($urandom_range(0, 7));
      img_words.delete();
      for (int i = 0; i < n; i++) img_words.push_back($urandom);
      run_image(n, int'($urandom_range(0, 50)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
